// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master port between NUM_REQ requesters, round-robin by default.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, rr pointer held at 0).
module apb_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_SLAVES = 5,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [31:0]            req_rdata,
    output logic                   m_transfer,
    output logic                   m_write,
    output logic [31:0]            m_addr,
    output logic [31:0]            m_wdata,
    input  logic                   m_ready,
    input  logic [31:0]            m_rdata,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLAVES);

    state_t               state_r;
    state_t               state_next_s;
    logic                 err_phase_r;
    logic                 err_phase_next_s;
    logic [GW-1:0]        rr_ptr_r;
    logic [GW-1:0]        rr_next_s;
    logic [GW-1:0]        grant_id_r;
    logic                 m_write_r;
    logic [31:0]          m_addr_r;
    logic [31:0]          m_wdata_r;
    logic                 m_transfer_r;
    logic [NUM_REQ-1:0]   req_done_r;
    logic [NUM_REQ-1:0]   req_err_r;
    logic [31:0]          req_rdata_r;
    logic                 busy_r;
    logic [GW-1:0]        win_idx_s;
    logic [31:0]          win_addr_s;
    logic [31:0]          win_wdata_s;
    logic                 win_write_s;
    logic                 grant_load_s;
    logic                 done_set_s;
    logic                 err_set_s;
    logic                 rr_adv_s;

    function automatic logic is_mapped(input logic [31:0] addr);
        return (addr[31:16] == 16'h1000) && ({1'b0, addr[15:12]} < SLOT_LIMIT);
    endfunction

    // First set bit scanning upward from ptr, wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        for (int k = 0; k < NUM_REQ; k++) begin
            v[k] = (GW'(k) == idx);
        end
        return v;
    endfunction

    assign win_idx_s   = rr_pick(req_valid, rr_ptr_r);
    assign win_addr_s  = req_addr[32*win_idx_s +: 32];
    assign win_wdata_s = req_wdata[32*win_idx_s +: 32];
    assign win_write_s = req_write[win_idx_s];

    // Pointer value after a completed or rejected transaction.
    always_comb begin
        rr_next_s = '0;
`ifdef APB_ARB_FIXED_PRIO_EN
        rr_next_s = '0;
`else
        if (grant_id_r == GW'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_id_r + GW'(1);
        end
`endif
    end

    // Next-state logic and per-transition strobes.
    always_comb begin
        state_next_s     = state_r;
        err_phase_next_s = 1'b0;
        grant_load_s     = 1'b0;
        done_set_s       = 1'b0;
        err_set_s        = 1'b0;
        rr_adv_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_load_s = 1'b1;
                    state_next_s = is_mapped(win_addr_s) ? ST_ISSUE : ST_ERR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE:  state_next_s = ST_SETUP;
            ST_SETUP:  state_next_s = ST_ACCESS;
            ST_ACCESS: begin
                if (m_ready) begin
                    done_set_s   = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                rr_adv_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            // Two cycles so the error pulse lands while still out of IDLE.
            ST_ERR: begin
                if (!err_phase_r) begin
                    err_phase_next_s = 1'b1;
                    err_set_s        = 1'b1;
                    state_next_s     = ST_ERR;
                end else begin
                    rr_adv_s         = 1'b1;
                    state_next_s     = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, error phase and arbitration pointer registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= ST_IDLE;
            err_phase_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            state_r     <= state_next_s;
            err_phase_r <= err_phase_next_s;
            if (rr_adv_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Winner payload latched at grant and held until the next grant.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            grant_id_r <= '0;
            m_write_r  <= 1'b0;
            m_addr_r   <= 32'd0;
            m_wdata_r  <= 32'd0;
        end else if (grant_load_s) begin
            grant_id_r <= win_idx_s;
            m_write_r  <= win_write_s;
            m_addr_r   <= win_addr_s;
            m_wdata_r  <= win_wdata_s;
        end
    end

    // Registered strobes and status decoded from the upcoming state.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_transfer_r <= 1'b0;
            busy_r       <= 1'b0;
            req_done_r   <= '0;
            req_err_r    <= '0;
            req_rdata_r  <= 32'd0;
        end else begin
            m_transfer_r <= (state_next_s == ST_ISSUE);
            busy_r       <= (state_next_s != ST_IDLE);
            req_done_r   <= done_set_s ? onehot(grant_id_r) : '0;
            req_err_r    <= err_set_s ? onehot(grant_id_r) : '0;
            req_rdata_r  <= done_set_s ? m_rdata : 32'd0;
        end
    end

    assign req_done   = req_done_r;
    assign req_err    = req_err_r;
    assign req_rdata  = req_rdata_r;
    assign m_transfer = m_transfer_r;
    assign m_write    = m_write_r;
    assign m_addr     = m_addr_r;
    assign m_wdata    = m_wdata_r;
    assign grant_id   = grant_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NUM_REQ=2, NUM_SLAVES=5); expectations are hand-computed.
module tb_apb_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int GW      = 1;

    logic                  PCLK = 1'b0;
    logic                  PRESET;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic [31:0]           req_rdata;
    logic                  m_transfer;
    logic                  m_write;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic                  m_ready;
    logic [31:0]           m_rdata;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    int checks   = 0;
    int failures = 0;
    int n;
    int xfers;
    int dones;
`ifdef APB_ARB_FIXED_PRIO_EN
    int exp_order [4] = '{0, 0, 0, 0};
`else
    int exp_order [4] = '{0, 1, 0, 1};
`endif
    logic [31:0] bad_addr [2] = '{32'h2000_0000, 32'h1000_5000};

    apb_req_arbiter #(.NUM_REQ(2), .NUM_SLAVES(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_transfer(output int cnt);
        cnt = 0;
        while (m_transfer !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("transfer_seen", 32'(m_transfer), 32'd1);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (req_done === '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("done_seen", 32'(req_done != '0), 32'd1);
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ready   = 1'b0;
        m_rdata   = 32'd0;
        tick();
        tick();
        chk("rst_transfer", 32'(m_transfer), 32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_done",     32'(req_done),   32'd0);
        chk("rst_err",      32'(req_err),    32'd0);
        chk("rst_addr",     m_addr,          32'd0);
        chk("rst_grant",    32'(grant_id),   32'd0);
        PRESET = 1'b0;
        tick();

        // Single zero-wait read from requester 0
        req_addr[31:0] = 32'h1000_1004;
        m_ready        = 1'b1;
        m_rdata        = 32'hDEAD_BEEF;
        req_valid      = 2'b01;
        chk("t1_c0_transfer", 32'(m_transfer), 32'd0);
        tick();
        chk("t1_c1_transfer", 32'(m_transfer), 32'd1);
        chk("t1_c1_addr",     m_addr,          32'h1000_1004);
        chk("t1_c1_write",    32'(m_write),    32'd0);
        chk("t1_c1_grant",    32'(grant_id),   32'd0);
        chk("t1_c1_busy",     32'(busy),       32'd1);
        tick();
        chk("t1_c2_transfer", 32'(m_transfer), 32'd0);
        tick();
        chk("t1_c3_done",     32'(req_done),   32'd0);
        tick();
        chk("t1_c4_done",     32'(req_done),   32'd1);
        chk("t1_c4_rdata",    req_rdata,       32'hDEAD_BEEF);
        req_valid = 2'b00;
        tick();
        chk("t1_c5_busy",     32'(busy),       32'd0);
        chk("t1_c5_done",     32'(req_done),   32'd0);

        // Write from requester 1 with three wait states
        m_ready          = 1'b0;
        m_rdata          = 32'h5555_AAAA;
        req_addr[63:32]  = 32'h1000_4000;
        req_wdata[63:32] = 32'h1234_5678;
        req_write        = 2'b10;
        req_valid        = 2'b10;
        tick();
        chk("t2_c1_transfer", 32'(m_transfer), 32'd1);
        chk("t2_c1_grant",    32'(grant_id),   32'd1);
        chk("t2_c1_write",    32'(m_write),    32'd1);
        chk("t2_c1_addr",     m_addr,          32'h1000_4000);
        chk("t2_c1_wdata",    m_wdata,         32'h1234_5678);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk("t2_hold_addr",     m_addr,          32'h1000_4000);
            chk("t2_hold_wdata",    m_wdata,         32'h1234_5678);
            chk("t2_hold_write",    32'(m_write),    32'd1);
            chk("t2_hold_transfer", 32'(m_transfer), 32'd0);
            chk("t2_hold_done",     32'(req_done),   32'd0);
            if (c == 6) m_ready = 1'b1;
        end
        tick();
        chk("t2_c7_done", 32'(req_done), 32'd2);
        req_valid = 2'b00;
        req_write = 2'b00;
        tick();
        chk("t2_c8_busy", 32'(busy), 32'd0);

        // Both requesters continuously valid for four transactions
        req_addr[31:0]  = 32'h1000_0000;
        req_addr[63:32] = 32'h1000_2000;
        req_valid       = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_transfer(n);
            if (t > 0) chk("t3_b2b_gap", 32'(n), 32'd2);
            chk("t3_grant", 32'(grant_id), 32'(exp_order[t]));
            chk("t3_addr",  m_addr, (exp_order[t] == 0) ? 32'h1000_0000 : 32'h1000_2000);
            wait_done(n);
            chk("t3_latency", 32'(n), 32'd3);
            chk("t3_done", 32'(req_done), 32'd1 << exp_order[t]);
        end
        req_valid = 2'b00;
        tick();
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // Unmapped addresses rejected locally
        m_rdata = 32'hDEAD_BEEF;
        for (int t = 0; t < 2; t++) begin
            req_addr[31:0] = bad_addr[t];
            req_valid      = 2'b01;
            tick();
            chk("t4_c1_err",      32'(req_err),    32'd0);
            chk("t4_c1_transfer", 32'(m_transfer), 32'd0);
            chk("t4_c1_busy",     32'(busy),       32'd1);
            tick();
            chk("t4_c2_err",      32'(req_err),    32'd1);
            chk("t4_c2_rdata",    req_rdata,       32'd0);
            chk("t4_c2_transfer", 32'(m_transfer), 32'd0);
            chk("t4_c2_done",     32'(req_done),   32'd0);
            req_valid = 2'b00;
            tick();
            chk("t4_c3_err",      32'(req_err),    32'd0);
            chk("t4_c3_busy",     32'(busy),       32'd0);
            chk("t4_c3_transfer", 32'(m_transfer), 32'd0);
        end

        // Reset while in ACCESS, then a fresh request
        req_addr[63:32]  = 32'h1000_3008;
        req_wdata[63:32] = 32'hA5A5_5A5A;
        req_write        = 2'b10;
        m_ready          = 1'b0;
        req_valid        = 2'b10;
        tick();
        tick();
        tick();
        chk("t5_pre_busy", 32'(busy), 32'd1);
        chk("t5_pre_addr", m_addr,    32'h1000_3008);
        PRESET    = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("t5_rst_transfer", 32'(m_transfer), 32'd0);
        chk("t5_rst_write",    32'(m_write),    32'd0);
        chk("t5_rst_addr",     m_addr,          32'd0);
        chk("t5_rst_wdata",    m_wdata,         32'd0);
        chk("t5_rst_grant",    32'(grant_id),   32'd0);
        chk("t5_rst_busy",     32'(busy),       32'd0);
        chk("t5_rst_done",     32'(req_done),   32'd0);
        chk("t5_rst_err",      32'(req_err),    32'd0);
        chk("t5_rst_rdata",    req_rdata,       32'd0);
        tick();
        PRESET  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_after_done", 32'(req_done), 32'd0);
            chk("t5_after_busy", 32'(busy),     32'd0);
        end
        req_addr[31:0] = 32'h1000_0010;
        req_write      = 2'b00;
        m_rdata        = 32'h0BAD_F00D;
        req_valid      = 2'b11;
        wait_transfer(n);
        chk("t5_new_latency", 32'(n),        32'd1);
        chk("t5_new_grant",   32'(grant_id), 32'd0);
        wait_done(n);
        chk("t5_new_done",    32'(req_done), 32'd1);
        chk("t5_new_rdata",   req_rdata,     32'h0BAD_F00D);
        req_valid = 2'b00;
        tick();

        // Requester drops valid right after grant
        req_addr[63:32] = 32'h1000_2020;
        m_rdata         = 32'h1111_2222;
        req_valid       = 2'b10;
        tick();
        chk("t6_c1_transfer", 32'(m_transfer), 32'd1);
        chk("t6_c1_grant",    32'(grant_id),   32'd1);
        req_valid = 2'b00;
        xfers = 0;
        dones = 0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (m_transfer === 1'b1) xfers++;
            if (req_done !== '0) dones++;
            if (c == 4) chk("t6_c4_done", 32'(req_done), 32'd2);
        end
        chk("t6_extra_transfers", 32'(xfers), 32'd0);
        chk("t6_done_count",      32'(dones), 32'd1);
        chk("t6_end_busy",        32'(busy),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master internal port (transfer/ready/write/addr/wdata/rdata) between NUM_REQ bus requesters, e.g. CPU data port and DMA.
- Arbitrates round-robin and latches the winning request.
- Sequences the master's IDLE/SETUP/ACCESS phases, returns read data and a completion pulse to the winner.
- Rejects unmapped addresses locally so the master never hangs on an unselected slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- NUM_SLAVES, 5, mapped slave windows at 0x1000_0000 + k*0x1000, k < NUM_SLAVES
- GW, $clog2(NUM_REQ) (min 1), grant index width (derived localparam)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request; held high until req_done/req_err
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  32*NUM_REQ  flattened addresses, requester i at [32i+31:32i]
- req_wdata  in  32*NUM_REQ  flattened write data
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  out  NUM_REQ  one-cycle error pulse for an unmapped address
- req_rdata  out  32  read data; valid while req_done/req_err high
- m_transfer  out  1  to APB master transfer
- m_write  out  1  to APB master write
- m_addr  out  32  to APB master addr
- m_wdata  out  32  to APB master wdata
- m_ready  in  1  from APB master ready
- m_rdata  in  32  from APB master rdata
- grant_id  out  GW  index of the current or last grant
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, PRESET=1): state=IDLE; all outputs 0; rr pointer=0; latched payload=0. Reset mid-transaction abandons it with no done pulse.
- States: IDLE, ISSUE, SETUP, ACCESS, DONE, ERR.
- IDLE:
  - If any req_valid: pick the first set bit scanning from rr pointer upward, wrapping modulo NUM_REQ.
  - Register grant_id, write, addr and wdata of the winner.
  - Mapped address (addr[31:16]==16'h1000 and addr[15:12] < NUM_SLAVES) -> ISSUE; otherwise -> ERR.
- ISSUE: m_transfer=1 for exactly this cycle; m_addr/m_write/m_wdata driven from latched regs -> SETUP.
- SETUP: master in SETUP; m_ready ignored -> ACCESS.
- ACCESS: wait for m_ready=1. On m_ready, capture m_rdata (writes capture it too; value unspecified for writes) -> DONE. No timeout.
- DONE: req_done[grant_id]=1, req_rdata=captured data; rr pointer=grant_id+1 mod NUM_REQ -> IDLE.
- ERR: req_err[grant_id]=1, req_rdata=0, no APB transfer; rr pointer advances as in DONE -> IDLE.
- m_addr/m_write/m_wdata hold latched values in all states; m_transfer is 0 outside ISSUE.
- Latency: valid sampled in cycle 0 -> m_transfer cycle 1 -> master SETUP cycle 2 -> ACCESS cycle 3. Zero-wait ready in cycle 3 gives req_done in cycle 4. Each slave wait state adds 1. Unmapped address: req_err in cycle 2.
- IDLE is never entered in the same cycle as a pulse, so a requester sees its pulse before the next arbitration. Requester must drop or replace valid in the cycle after the pulse.
- Requester payload is sampled only at grant; later changes are ignored. A valid dropped after grant still completes and pulses.
- Simultaneous requests: one grant per transaction; no starvation, since every waiting requester is served within NUM_REQ transactions.
- Back-to-back: the next m_transfer comes no earlier than 2 cycles after req_done, matching the master's return to IDLE.

Optional Feature:
- Macro APB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr pointer unused and held at 0.
- Undefined: round-robin as above.

Test Plan:
- Single read, req 0 addr 0x1000_1004, slave PREADY zero-wait, rdata 0xDEADBEEF -> m_transfer in cycle 1 only; req_done[0] in cycle 4 with req_rdata=0xDEADBEEF; busy low in cycle 5.
- Write from req 1 to 0x1000_4000, wdata 0x1234_5678, slave inserts 3 wait states -> m_addr/m_wdata/m_write=1 stable from cycle 1 through ACCESS; req_done[1] in cycle 7.
- req 0 and req 1 both continuously valid for 4 transactions -> grant order 0,1,0,1. With APB_ARB_FIXED_PRIO_EN defined: 0,0,0,0.
- req 0 addr 0x2000_0000 (unmapped) and 0x1000_5000 (slot 5 >= NUM_SLAVES) -> req_err[0] in cycle 2, req_rdata=0, m_transfer never asserted.
- PRESET pulsed while in ACCESS -> all outputs 0, no req_done. A new request after reset completes normally with grant to the lowest valid index.
- Requester drops req_valid the cycle after grant -> transaction still completes; req_done pulses once and no second m_transfer is issued.
